// File: rtl/seg7_scan_if.sv
// Bundle between the register/counter logic (master) and the 7-segment scan
// controller (slave): frame load strobe, scan enable and display-side outputs.
interface seg7_scan_if #(
  parameter int N_DIGITS = 4
);
  logic                    en;
  logic                    load;
  logic [4*N_DIGITS-1:0]   digits_in;
  logic [3:0]              bcd_out;
  logic [N_DIGITS-1:0]     an_n;
  logic                    frame_done;

  modport master (
    output en, load, digits_in,
    input  bcd_out, an_n, frame_done
  );

  modport slave (
    input  en, load, digits_in,
    output bcd_out, an_n, frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Define SEG7_LZS_EN to enable leading-zero suppression of the displayed frame.
module seg7_scan_ctrl #(
  parameter int N_DIGITS     = 4,
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic         clk,
  input  logic         rst_n,
  seg7_scan_if.slave   bus
);
  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int SEL_W = $clog2(N_DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON} state_t;

  state_t                state_q, state_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4*N_DIGITS-1:0] active_q, active_d;
  logic [4*N_DIGITS-1:0] staging_q, staging_d;
  logic                  pending_q, pending_d;
  logic [3:0]            bcd_q, bcd_d;
  logic [N_DIGITS-1:0]   an_n_q, an_n_d;
  logic                  frame_done_q, frame_done_d;
  logic [N_DIGITS-1:0]   supp_d;
  logic                  swap;
  logic                  lit;

  // Slot timing: cnt runs 0..DIGIT_CYCLES-1 across the blank and on phases.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    swap    = 1'b0;
    if (!bus.en) begin
      state_d = S_IDLE;
      sel_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_BLANK;
          sel_d   = '0;
          cnt_d   = '0;
          swap    = 1'b1;
        end
        S_BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) state_d = S_ON;
        end
        S_ON: begin
          if (cnt_q == CNT_W'(DIGIT_CYCLES - 1)) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            if (sel_q == SEL_W'(N_DIGITS - 1)) begin
              sel_d = '0;
              swap  = 1'b1;
            end else begin
              sel_d = sel_q + SEL_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A load coinciding with the frame-start swap bypasses staging into active.
  always_comb begin
    staging_d = bus.load ? bus.digits_in : staging_q;
    pending_d = swap ? 1'b0 : (bus.load | pending_q);
    active_d  = active_q;
    if (swap) active_d = bus.load ? bus.digits_in : staging_q;
  end

`ifdef SEG7_LZS_EN
  logic [N_DIGITS-1:0] supp_q;
  logic [N_DIGITS-1:0] supp_calc;
  logic                zero_run;

  always_comb begin
    zero_run  = 1'b1;
    supp_calc = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run     = zero_run && (active_d[4*i +: 4] == 4'd0);
      supp_calc[i] = zero_run;
    end
    supp_d = swap ? supp_calc : supp_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) supp_q <= '0;
    else        supp_q <= supp_d;
  end
`else
  assign supp_d = '0;
`endif

  // Outputs are derived from the next state so they are registered with it.
  always_comb begin
    bcd_d = bcd_q;
    if (state_d == S_BLANK && state_q != S_BLANK)
      bcd_d = active_d[4*int'(sel_d) +: 4];
    lit          = (state_d == S_ON) && (bcd_d <= 4'd9) && !supp_d[sel_d];
    an_n_d       = lit ? ~(N_DIGITS'(1) << sel_d) : '1;
    frame_done_d = (state_d == S_ON) && (cnt_d == CNT_W'(DIGIT_CYCLES - 1)) &&
                   (sel_d == SEL_W'(N_DIGITS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      cnt_q        <= '0;
      active_q     <= '0;
      staging_q    <= '0;
      pending_q    <= 1'b0;
      bcd_q        <= 4'd0;
      an_n_q       <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      staging_q    <= staging_d;
      pending_q    <= pending_d;
      bcd_q        <= bcd_d;
      an_n_q       <= an_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.bcd_out    = bcd_q;
  assign bus.an_n       = an_n_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with a frame-level reference model and
// per-cycle comparison (4 digits, 8-cycle slots, 2 blank cycles).
module tb_seg7_scan_ctrl;
  localparam int N  = 4;
  localparam int DC = 8;
  localparam int BC = 2;
  localparam int FL = N * DC;
`ifdef SEG7_LZS_EN
  localparam bit LZS = 1'b1;
`else
  localparam bit LZS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  seg7_scan_if #(.N_DIGITS(N)) sif ();

  seg7_scan_ctrl #(.N_DIGITS(N), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position in frame t decides slot and phase directly.
  bit          m_run = 1'b0;
  int          m_t = 0;
  logic [15:0] m_frame = '0;
  logic [15:0] m_stage = '0;
  logic [3:0]  m_bcd = '0;
  logic [3:0]  m_an = 4'hF;
  logic        m_fd = 1'b0;

  function automatic bit suppressed(input logic [15:0] f, input int slot);
    return LZS && (slot > 0) && ((f >> (4 * slot)) == 16'd0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 1'b0; m_t = 0; m_frame = '0; m_stage = '0;
      m_bcd = '0; m_an = 4'hF; m_fd = 1'b0;
    end else begin
      int         slot;
      int         ph;
      logic [3:0] dig;
      bit         on;
      if (!sif.en) begin
        m_run = 1'b0; m_an = 4'hF; m_fd = 1'b0;
      end else begin
        if (!m_run) begin m_run = 1'b1; m_t = 0; end
        else m_t = (m_t + 1) % FL;
        if (m_t == 0) m_frame = sif.load ? sif.digits_in : m_stage;
        slot = m_t / DC;
        ph   = m_t % DC;
        dig  = m_frame[4*slot +: 4];
        if (ph == 0) m_bcd = dig;
        on   = (ph >= BC) && (dig <= 4'd9) && !suppressed(m_frame, slot);
        m_an = on ? ~(4'b0001 << slot) : 4'hF;
        m_fd = (m_t == FL - 1);
      end
      if (sif.load) m_stage = sif.digits_in;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("bcd_out", {12'd0, sif.bcd_out}, {12'd0, m_bcd});
      chk("an_n", {12'd0, sif.an_n}, {12'd0, m_an});
      chk("frame_done", {15'd0, sif.frame_done}, {15'd0, m_fd});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lit_chk(input string name, input logic [3:0] an, input logic [3:0] bcd);
    chk({name, "_an"}, {12'd0, sif.an_n}, {12'd0, an});
    chk({name, "_bcd"}, {12'd0, sif.bcd_out}, {12'd0, bcd});
  endtask

  initial begin
    int fdcnt;
    sif.en = 1'b0; sif.load = 1'b0; sif.digits_in = '0;
    step(3);
    lit_chk("in_reset", 4'hF, 4'h0);
    chk("in_reset_fd", {15'd0, sif.frame_done}, 16'd0);
    rst_n = 1'b1;

    sif.load = 1'b1; sif.digits_in = 16'h4321;
    step(1);
    sif.load = 1'b0;
    step(10);
    lit_chk("disabled", 4'hF, 4'h0);

    sif.en = 1'b1;
    step(1);
    lit_chk("first_blank", 4'hF, 4'h1);
    step(2);
    lit_chk("digit0", 4'b1110, 4'h1);
    step(8);
    lit_chk("digit1", 4'b1101, 4'h2);
    fdcnt = 0;
    for (int i = 0; i < 2 * FL; i++) begin
      step(1);
      fdcnt += int'(sif.frame_done);
    end
    chk("frame_done_count", 16'(fdcnt), 16'd2);

    sif.load = 1'b1; sif.digits_in = 16'h9876;
    step(1);
    sif.load = 1'b0;
    step(7);
    lit_chk("old_frame_d2", 4'b1011, 4'h3);
    step(16);
    lit_chk("new_frame_d0", 4'b1110, 4'h6);

    step(29);
    sif.load = 1'b1; sif.digits_in = 16'h0A05;
    step(1);
    sif.load = 1'b0;
    step(2);
    lit_chk("swap_load_d0", 4'b1110, 4'h5);
    step(8);
    lit_chk("zero_mid_d1", 4'b1101, 4'h0);
    step(8);
    lit_chk("invalid_d2", 4'b1111, 4'hA);
    step(8);
    lit_chk("d3_zero", LZS ? 4'b1111 : 4'b0111, 4'h0);

    step(19);
    sif.en = 1'b0;
    step(1);
    lit_chk("en_drop", 4'hF, 4'h0);
    chk("en_drop_fd", {15'd0, sif.frame_done}, 16'd0);
    step(5);
    lit_chk("en_low_hold", 4'hF, 4'h0);
    sif.en = 1'b1;
    step(1);
    lit_chk("reen_blank", 4'hF, 4'h5);
    step(2);
    lit_chk("reen_d0", 4'b1110, 4'h5);

    sif.en = 1'b0; sif.load = 1'b1; sif.digits_in = 16'h0070;
    step(1);
    sif.load = 1'b0; sif.en = 1'b1;
    step(3);
    lit_chk("lzs70_d0", 4'b1110, 4'h0);
    step(8);
    lit_chk("lzs70_d1", 4'b1101, 4'h7);
    step(8);
    lit_chk("lzs70_d2", LZS ? 4'b1111 : 4'b1011, 4'h0);
    step(8);
    lit_chk("lzs70_d3", LZS ? 4'b1111 : 4'b0111, 4'h0);
    step(5);
    sif.load = 1'b1; sif.digits_in = 16'h0000;
    step(1);
    sif.load = 1'b0;
    step(2);
    lit_chk("lzs00_d0", 4'b1110, 4'h0);
    step(8);
    lit_chk("lzs00_d1", LZS ? 4'b1111 : 4'b1101, 4'h0);

    sif.load = 1'b1; sif.digits_in = 16'h5555;
    step(1);
    sif.load = 1'b0;
    step(23);
    lit_chk("pre_reset", 4'b1110, 4'h5);
    #2;
    rst_n = 1'b0;
    #1;
    lit_chk("async_reset", 4'hF, 4'h0);
    chk("async_reset_fd", {15'd0, sif.frame_done}, 16'd0);
    sif.en = 1'b0;
    #2;
    rst_n = 1'b1;
    step(3);
    lit_chk("post_reset", 4'hF, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
